// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, FSM state encoding and sizing helpers for the VGA raster generator.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_DIV      = 4;
  localparam int DEF_CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate divider: tick is high on the last clk of every DIV-clk pixel period; clr parks it at 0.
module vga_tick_div
  import vga_timing_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

  assign tick = (div_cnt == LAST) && !clr;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with run/drain control and sof/eol strobes.
// Define VGA_TIMING_FRAME_CNT_EN to enable the 16-bit frame counter (otherwise frame_cnt reads 0).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   DIV      = DEF_DIV,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic             busy,
  output logic             p_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             sof,
  output logic             eol,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  state_t           state, state_nxt;
  logic             tick, div_clr, busy_nxt, frame_last;
  logic [CNT_W-1:0] x_nxt, y_nxt;

  assign busy    = (state != IDLE);
  assign div_clr = ~busy;

  vga_tick_div #(.DIV(DIV)) u_tick_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (div_clr),
    .tick    (tick)
  );

  assign p_tick     = tick && busy;
  assign frame_last = (pixel_x == H_LAST) && (pixel_y == V_LAST);
  assign sof        = p_tick && (pixel_x == '0) && (pixel_y == '0) && busy;
  assign eol        = p_tick && (pixel_x == H_LAST);

  always_comb begin
    x_nxt = pixel_x;
    y_nxt = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
      end else begin
        x_nxt = pixel_x + CNT_W'(1);
      end
    end
  end

  // DRAIN keeps the raster running so a frame is never cut short; it only parks at the frame end.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                        state_nxt = RUN;
        else if (p_tick && frame_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Sync and blanking decode the next count so they switch on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      video_on <= 1'b0;
    end else begin
      state    <= state_nxt;
      pixel_x  <= x_nxt;
      pixel_y  <= y_nxt;
      hsync    <= ((x_nxt >= HS_START) && (x_nxt <= HS_END)) ? HS_POL : ~HS_POL;
      vsync    <= ((y_nxt >= VS_START) && (y_nxt <= VS_END)) ? VS_POL : ~VS_POL;
      video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS) && busy_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frames;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames <= '0;
    end else if (sof) begin
      frames <= frames + 16'd1;
    end
  end

  assign frame_cnt = frames;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default 640x480 instance, a reduced DIV=4 instance for
// frame-level behaviour, and an 8x4 DIV=1 instance with active-high syncs.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC = 1;
`else
  localparam int FC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: default timing
  logic        rst_a = 1'b1, en_a = 1'b0;
  logic        busy_a, p_tick_a, hsync_a, vsync_a, video_on_a, sof_a, eol_a;
  logic [9:0]  px_a, py_a;
  logic [15:0] fc_a;
  // Instance B: 28x19 total, DIV=4
  logic        rst_b = 1'b1, en_b = 1'b0;
  logic        busy_b, p_tick_b, hsync_b, vsync_b, video_on_b, sof_b, eol_b;
  logic [7:0]  px_b, py_b;
  logic [15:0] fc_b;
  // Instance C: 12x7 total, DIV=1, active-high syncs
  logic        rst_c = 1'b1, en_c = 1'b0;
  logic        busy_c, p_tick_c, hsync_c, vsync_c, video_on_c, sof_c, eol_c;
  logic [3:0]  px_c, py_c;
  logic [15:0] fc_c;

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(rst_a), .en(en_a), .busy(busy_a), .p_tick(p_tick_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a), .pixel_x(px_a),
    .pixel_y(py_a), .sof(sof_a), .eol(eol_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .DIV(4), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .en(en_b), .busy(busy_b), .p_tick(p_tick_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b), .pixel_x(px_b),
    .pixel_y(py_b), .sof(sof_b), .eol(eol_b), .frame_cnt(fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) dut_c (
    .clk(clk), .reset_n(rst_c), .en(en_c), .busy(busy_c), .p_tick(p_tick_c),
    .hsync(hsync_c), .vsync(vsync_c), .video_on(video_on_c), .pixel_x(px_c),
    .pixel_y(py_c), .sof(sof_c), .eol(eol_c), .frame_cnt(fc_c)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event at %0d, expected no event (t=%0t)", name, act, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit vo;
    bit pt;
    bit eol;
    bit sof;
  } c_exp_t;

  longint sof_q_a[$], eol_q_a[$], hs_q_a[$], vo_q_a[$];
  longint sof_q_b[$], vs_q_b[$], bf_q_b[$];
  c_exp_t c_q[$];

  bit ma_on = 1'b0, mb_on = 1'b0, mc_on = 1'b0;
  int tick_cnt_a = 0;

  // Monitor A: strobe timing and hsync/video_on transition positions
  initial begin
    logic hs_prev, vo_prev;
    hs_prev = 1'b1;
    vo_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (p_tick_a === 1'b1) tick_cnt_a++;
      if (ma_on) begin
        if (sof_a === 1'b1) begin
          if (sof_q_a.size() == 0) unexpected("a_sof_cycle", cyc);
          else chk("a_sof_cycle", cyc, sof_q_a.pop_front());
        end
        if (eol_a === 1'b1) begin
          if (eol_q_a.size() == 0) unexpected("a_eol_cycle", cyc);
          else chk("a_eol_cycle", cyc, eol_q_a.pop_front());
        end
        if (hsync_a !== hs_prev) begin
          if (hs_q_a.size() == 0) unexpected("a_hsync_edge_x", px_a);
          else chk("a_hsync_edge_x", px_a, hs_q_a.pop_front());
        end
        if (video_on_a !== vo_prev) begin
          if (vo_q_a.size() == 0) unexpected("a_video_on_edge_x", px_a);
          else chk("a_video_on_edge_x", px_a, vo_q_a.pop_front());
        end
      end
      hs_prev = hsync_a;
      vo_prev = video_on_a;
    end
  end

  // Monitor B: sof timing, vsync transition lines, busy falling edge timing
  initial begin
    logic vs_prev, busy_prev;
    vs_prev   = 1'b1;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mb_on) begin
        if (sof_b === 1'b1) begin
          if (sof_q_b.size() == 0) unexpected("b_sof_cycle", cyc);
          else chk("b_sof_cycle", cyc, sof_q_b.pop_front());
        end
        if (vsync_b !== vs_prev) begin
          if (vs_q_b.size() == 0) unexpected("b_vsync_edge_y", py_b);
          else begin
            chk("b_vsync_edge_y", py_b, vs_q_b.pop_front());
            chk("b_vsync_edge_x", px_b, 0);
          end
        end
        if ((busy_prev === 1'b1) && (busy_b === 1'b0)) begin
          if (bf_q_b.size() == 0) unexpected("b_busy_fall_cycle", cyc);
          else chk("b_busy_fall_cycle", cyc, bf_q_b.pop_front());
        end
      end
      vs_prev   = vsync_b;
      busy_prev = busy_b;
    end
  end

  // Monitor C: cycle-by-cycle expected raster
  initial begin
    c_exp_t e;
    forever begin
      @(negedge clk);
      if (mc_on && (c_q.size() > 0)) begin
        e = c_q.pop_front();
        chk("c_busy", busy_c, 1);
        chk("c_p_tick", p_tick_c, e.pt);
        chk("c_pixel_x", px_c, e.x);
        chk("c_pixel_y", py_c, e.y);
        chk("c_hsync", hsync_c, e.hs);
        chk("c_vsync", vsync_c, e.vs);
        chk("c_video_on", video_on_c, e.vo);
        chk("c_eol", eol_c, e.eol);
        chk("c_sof", sof_c, e.sof);
      end
    end
  end

  initial begin
    longint k, m;
    c_exp_t e;

    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    step();
    step();
    chk("a_rst_hsync", hsync_a, 1);
    chk("a_rst_vsync", vsync_a, 1);
    chk("a_rst_video_on", video_on_a, 0);
    chk("a_rst_pixel_x", px_a, 0);
    chk("a_rst_pixel_y", py_a, 0);
    chk("a_rst_busy", busy_a, 0);
    chk("a_rst_p_tick", p_tick_a, 0);
    chk("a_rst_sof", sof_a, 0);
    chk("a_rst_eol", eol_a, 0);
    chk("a_rst_frame_cnt", fc_a, 0);
    chk("c_rst_hsync", hsync_c, 0);
    chk("c_rst_vsync", vsync_c, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (100) step();
    chk("a_idle_p_ticks", tick_cnt_a, 0);
    chk("a_idle_busy", busy_a, 0);

    // A: first three lines of the default raster
    k = cyc;
    sof_q_a.push_back(k + 4);
    vo_q_a.push_back(0);
    for (int l = 1; l <= 3; l++) begin
      eol_q_a.push_back(k + 3200 * l);
      hs_q_a.push_back(656);
      hs_q_a.push_back(752);
      vo_q_a.push_back(640);
      vo_q_a.push_back(0);
    end
    en_a  = 1'b1;
    ma_on = 1'b1;
    while (cyc < k + 9602) step();
    ma_on = 1'b0;
    chk("a_busy_running", busy_a, 1);
    chk("a_pixel_y_line3", py_a, 3);
    chk("a_frame_cnt", fc_a, FC * 1);
    rst_a = 1'b0;
    en_a  = 1'b0;

    // B: three frames, en blip in frame 1, drain from frame 2 line 5
    step();
    k = cyc;
    sof_q_b.push_back(k + 4);
    sof_q_b.push_back(k + 2132);
    sof_q_b.push_back(k + 4260);
    for (int f = 0; f < 3; f++) begin
      vs_q_b.push_back(14);
      vs_q_b.push_back(16);
    end
    bf_q_b.push_back(k + 6385);
    en_b  = 1'b1;
    mb_on = 1'b1;
    while (cyc < k + 2470) step();
    chk("b_f1_pixel_y", py_b, 3);
    chk("b_f1_pixel_x", px_b, 1);
    en_b = 1'b0;
    repeat (10) step();
    chk("b_busy_in_drain", busy_b, 1);
    en_b = 1'b1;
    while (cyc < k + 4830) step();
    chk("b_f2_pixel_y", py_b, 5);
    chk("b_f2_pixel_x", px_b, 3);
    en_b = 1'b0;
    while (cyc < k + 6385) step();
    chk("b_idle_busy", busy_b, 0);
    chk("b_idle_pixel_x", px_b, 0);
    chk("b_idle_pixel_y", py_b, 0);
    chk("b_idle_video_on", video_on_b, 0);
    chk("b_idle_hsync", hsync_b, 1);
    chk("b_idle_vsync", vsync_b, 1);
    repeat (20) step();
    chk("b_parked_pixel_x", px_b, 0);
    chk("b_parked_pixel_y", py_b, 0);
    chk("b_frame_cnt", fc_b, FC * 3);

    // B: restart, then async reset at (10,7)
    step();
    m = cyc;
    sof_q_b.push_back(m + 4);
    en_b = 1'b1;
    while (cyc < m + 826) step();
    chk("b_mid_pixel_x", px_b, 10);
    chk("b_mid_pixel_y", py_b, 7);
    chk("b_mid_video_on", video_on_b, 1);
    chk("b_mid_frame_cnt", fc_b, FC * 4);
    bf_q_b.push_back(m + 827);
    rst_b = 1'b0;
    #1;
    chk("b_arst_busy", busy_b, 0);
    chk("b_arst_p_tick", p_tick_b, 0);
    chk("b_arst_pixel_x", px_b, 0);
    chk("b_arst_pixel_y", py_b, 0);
    chk("b_arst_hsync", hsync_b, 1);
    chk("b_arst_vsync", vsync_b, 1);
    chk("b_arst_video_on", video_on_b, 0);
    chk("b_arst_sof", sof_b, 0);
    chk("b_arst_frame_cnt", fc_b, 0);
    step();
    step();
    mb_on = 1'b0;
    en_b  = 1'b0;

    // C: two full frames at DIV=1, en dropped during frame 1
    step();
    k = cyc;
    for (int i = 0; i < 168; i++) begin
      int n;
      n     = i % 84;
      e.x   = n % 12;
      e.y   = n / 12;
      e.pt  = 1'b1;
      e.hs  = (e.x >= 9) && (e.x <= 10);
      e.vs  = (e.y == 5);
      e.vo  = (e.x < 8) && (e.y < 4);
      e.eol = (e.x == 11);
      e.sof = (n == 0);
      c_q.push_back(e);
    end
    en_c  = 1'b1;
    mc_on = 1'b1;
    for (int i = 0; (i < 400) && (c_q.size() > 0); i++) begin
      step();
      if (cyc == k + 100) en_c = 1'b0;
    end
    chk("c_expected_left", c_q.size(), 0);
    step();
    chk("c_idle_busy", busy_c, 0);
    chk("c_idle_p_tick", p_tick_c, 0);
    chk("c_idle_pixel_x", px_c, 0);
    chk("c_idle_pixel_y", py_c, 0);
    chk("c_frame_cnt", fc_c, FC * 2);
    mc_on = 1'b0;

    chk("a_sof_left", sof_q_a.size(), 0);
    chk("a_eol_left", eol_q_a.size(), 0);
    chk("a_hsync_left", hs_q_a.size(), 0);
    chk("a_video_on_left", vo_q_a.size(), 0);
    chk("b_sof_left", sof_q_b.size(), 0);
    chk("b_vsync_left", vs_q_b.size(), 0);
    chk("b_busy_fall_left", bf_q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
